// File: rtl/vga_pkg.sv
// VGA 1024x768@60 timing constants and shared stage payload type.
package vga_pkg;

  localparam int unsigned VISIBLE_WIDTH          = 1024;
  localparam int unsigned HORIZONTAL_FRONT_PORCH = 24;
  localparam int unsigned HORIZONTAL_SYNC_PULSE  = 136;
  localparam int unsigned FULL_WIDTH             = 1344;

  localparam int unsigned VISIBLE_HEIGHT         = 768;
  localparam int unsigned VERTICAL_FRONT_PORCH   = 3;
  localparam int unsigned VERTICAL_SYNC_PULSE    = 6;
  localparam int unsigned FULL_HEIGHT            = 806;

  localparam int unsigned H_SYNC_START = VISIBLE_WIDTH + HORIZONTAL_FRONT_PORCH;   // 1048
  localparam int unsigned H_SYNC_END   = H_SYNC_START + HORIZONTAL_SYNC_PULSE;     // 1184
  localparam int unsigned V_SYNC_START = VISIBLE_HEIGHT + VERTICAL_FRONT_PORCH;    // 771
  localparam int unsigned V_SYNC_END   = V_SYNC_START + VERTICAL_SYNC_PULSE;       // 777

  localparam int unsigned CNT_W = 11;

  // Raster position and flags as carried between draw stages.
  typedef struct packed {
    logic [CNT_W-1:0] vcount;
    logic             vsync;
    logic             vblnk;
    logic [CNT_W-1:0] hcount;
    logic             hsync;
    logic             hblnk;
  } vga_if_t;

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle: pixel enable in, counters and flags out.
interface vga_timing_if;
  import vga_pkg::*;

  logic             en;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hblnk;
  logic             vblnk;
  logic             hsync;
  logic             vsync;
  logic             frame_start;

  modport master (
    input  en,
    output hcount, vcount, hblnk, vblnk, hsync, vsync, frame_start
  );

  modport slave (
    output en,
    input  hcount, vcount, hblnk, vblnk, hsync, vsync, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with blank/sync flags derived from the
// next count so flags and count are registered together.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned VISIBLE    = VISIBLE_WIDTH,
  parameter int unsigned SYNC_START = H_SYNC_START,
  parameter int unsigned SYNC_END   = H_SYNC_END,
  parameter int unsigned TOTAL      = FULL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             blnk_o,
  output logic             sync_o,
  output logic             wrap_c_o
);

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS   = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] SSTRT = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] SEND  = CNT_W'(SYNC_END);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blnk_q, blnk_d;
  logic             sync_q, sync_d;
  logic             at_last;

  // Next count and the flags that will accompany it.
  always_comb begin
    cnt_d   = cnt_q;
    at_last = (cnt_q == LAST);
    if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
    end
    blnk_d = (cnt_d >= VIS);
    sync_d = (cnt_d >= SSTRT) && (cnt_d < SEND);
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      blnk_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      blnk_q <= blnk_d;
      sync_q <= sync_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign blnk_o   = blnk_q;
  assign sync_o   = sync_q;
  assign wrap_c_o = en_i && at_last;

endmodule

// File: rtl/vga_timing.sv
// Free-running VGA raster generator: horizontal and vertical axis counters
// plus a registered start-of-frame strobe.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VISIBLE_WIDTH,
  parameter int unsigned H_FRONT   = HORIZONTAL_FRONT_PORCH,
  parameter int unsigned H_SYNC    = HORIZONTAL_SYNC_PULSE,
  parameter int unsigned H_TOTAL   = FULL_WIDTH,
  parameter int unsigned V_VISIBLE = VISIBLE_HEIGHT,
  parameter int unsigned V_FRONT   = VERTICAL_FRONT_PORCH,
  parameter int unsigned V_SYNC    = VERTICAL_SYNC_PULSE,
  parameter int unsigned V_TOTAL   = FULL_HEIGHT
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_timing_if.master vga
);

  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic h_wrap_c;
  logic v_wrap_c;
  logic v_en_c;
  logic frame_start_q, frame_start_d;

  vga_axis_counter #(
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (HS_START),
    .SYNC_END   (HS_END),
    .TOTAL      (H_TOTAL)
  ) u_h (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (vga.en),
    .cnt_o    (vga.hcount),
    .blnk_o   (vga.hblnk),
    .sync_o   (vga.hsync),
    .wrap_c_o (h_wrap_c)
  );

  // Vertical axis steps once per completed line.
  assign v_en_c = vga.en && h_wrap_c;

  vga_axis_counter #(
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (VS_START),
    .SYNC_END   (VS_END),
    .TOTAL      (V_TOTAL)
  ) u_v (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (v_en_c),
    .cnt_o    (vga.vcount),
    .blnk_o   (vga.vblnk),
    .sync_o   (vga.vsync),
    .wrap_c_o (v_wrap_c)
  );

  // Strobe is set only when counting carries both axes back to origin.
  always_comb begin
    frame_start_d = v_wrap_c;
  end

  // Strobe register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: full 1024x768 instance for horizontal behaviour, enable
// and async reset; a scaled-down instance for vertical and frame behaviour.
module tb_vga_timing;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;

  int checks = 0;
  int errors = 0;

  int hs_cnt, hs_first, hs_last;
  int vs_cnt, vs_first, vs_last, vb_cnt, fs_cnt, n;

  vga_timing_if vga_a ();
  vga_timing_if vga_b ();

  vga_timing dut_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .vga   (vga_a)
  );

  // Small raster: H 8/2/3/16, V 6/1/2/10 -> hsync 10..12, vsync 7..8, 160 cycles/frame.
  vga_timing #(
    .H_VISIBLE (8),
    .H_FRONT   (2),
    .H_SYNC    (3),
    .H_TOTAL   (16),
    .V_VISIBLE (6),
    .V_FRONT   (1),
    .V_SYNC    (2),
    .V_TOTAL   (10)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .vga   (vga_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a_n  = 1'b0;
    rst_b_n  = 1'b0;
    vga_a.en = 1'b1;
    vga_b.en = 1'b1;

    // Reset held for 5 cycles
    tick(5);
    chk("rst_hcount", int'(vga_a.hcount), 0);
    chk("rst_vcount", int'(vga_a.vcount), 0);
    chk("rst_hblnk", int'(vga_a.hblnk), 0);
    chk("rst_vblnk", int'(vga_a.vblnk), 0);
    chk("rst_hsync", int'(vga_a.hsync), 0);
    chk("rst_vsync", int'(vga_a.vsync), 0);
    chk("rst_fs", int'(vga_a.frame_start), 0);

    // Release: counts 1,2,3
    rst_a_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      chk("rel_hcount", int'(vga_a.hcount), i);
      chk("rel_vcount", int'(vga_a.vcount), 0);
      chk("rel_fs", int'(vga_a.frame_start), 0);
    end

    // Visible edge
    tick(1020);
    chk("h1023_hcount", int'(vga_a.hcount), 1023);
    chk("h1023_hblnk", int'(vga_a.hblnk), 0);
    tick(1);
    chk("h1024_hcount", int'(vga_a.hcount), 1024);
    chk("h1024_hblnk", int'(vga_a.hblnk), 1);
    chk("h1024_hsync", int'(vga_a.hsync), 0);

    // Horizontal sync window over the rest of the line
    hs_cnt = 0; hs_first = -1; hs_last = -1;
    for (int i = 0; i < 319; i++) begin
      tick(1);
      if (vga_a.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(vga_a.hcount);
        hs_last = int'(vga_a.hcount);
      end
    end
    chk("hsync_len", hs_cnt, 136);
    chk("hsync_first", hs_first, 1048);
    chk("hsync_last", hs_last, 1183);
    chk("h1343_hcount", int'(vga_a.hcount), 1343);
    chk("h1343_hblnk", int'(vga_a.hblnk), 1);

    // Line wrap
    tick(1);
    chk("lw_hcount", int'(vga_a.hcount), 0);
    chk("lw_vcount", int'(vga_a.vcount), 1);
    chk("lw_hblnk", int'(vga_a.hblnk), 0);
    chk("lw_vblnk", int'(vga_a.vblnk), 0);
    chk("lw_fs", int'(vga_a.frame_start), 0);

    // Enable pattern 1,0,0,1 from hcount=500
    tick(500);
    chk("en_h500", int'(vga_a.hcount), 500);
    tick(1);
    chk("en_step1", int'(vga_a.hcount), 501);
    vga_a.en = 1'b0;
    tick(1);
    chk("en_hold1", int'(vga_a.hcount), 501);
    tick(1);
    chk("en_hold2", int'(vga_a.hcount), 501);
    vga_a.en = 1'b1;
    tick(1);
    chk("en_resume", int'(vga_a.hcount), 502);

    // Async reset between edges mid-line
    tick(198);
    chk("mid_hcount", int'(vga_a.hcount), 700);
    chk("mid_vcount", int'(vga_a.vcount), 1);
    #2;
    rst_a_n = 1'b0;
    #1;
    chk("arst_hcount", int'(vga_a.hcount), 0);
    chk("arst_vcount", int'(vga_a.vcount), 0);
    chk("arst_hblnk", int'(vga_a.hblnk), 0);
    chk("arst_fs", int'(vga_a.frame_start), 0);
    tick(2);
    rst_a_n = 1'b1;
    tick(1);
    chk("arel_hcount", int'(vga_a.hcount), 1);
    chk("arel_vcount", int'(vga_a.vcount), 0);
    chk("arel_fs", int'(vga_a.frame_start), 0);

    // Small raster: one full frame from release
    rst_b_n = 1'b1;
    vs_cnt = 0; vs_first = -1; vs_last = -1; vb_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 159; i++) begin
      tick(1);
      if (vga_b.vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = int'(vga_b.vcount);
        vs_last = int'(vga_b.vcount);
      end
      if (vga_b.vblnk) vb_cnt++;
      if (vga_b.frame_start) fs_cnt++;
    end
    chk("b_last_h", int'(vga_b.hcount), 15);
    chk("b_last_v", int'(vga_b.vcount), 9);
    chk("b_vsync_cycles", vs_cnt, 32);
    chk("b_vsync_first", vs_first, 7);
    chk("b_vsync_last", vs_last, 8);
    chk("b_vblnk_cycles", vb_cnt, 64);
    chk("b_no_early_fs", fs_cnt, 0);

    // Frame wrap
    tick(1);
    chk("b_fw_h", int'(vga_b.hcount), 0);
    chk("b_fw_v", int'(vga_b.vcount), 0);
    chk("b_fw_fs", int'(vga_b.frame_start), 1);
    chk("b_fw_vblnk", int'(vga_b.vblnk), 0);
    chk("b_fw_hblnk", int'(vga_b.hblnk), 0);

    // Pulse period, bounded
    n = 0;
    do begin
      tick(1);
      n++;
      if (n == 1) chk("b_fs_one_cycle", int'(vga_b.frame_start), 0);
    end while (!vga_b.frame_start && n < 400);
    chk("b_fs_period", n, 160);

    // en=0 right after a pulse clears the strobe
    vga_b.en = 1'b0;
    tick(1);
    chk("b_gate_fs_clear", int'(vga_b.frame_start), 0);
    chk("b_gate_hold_h", int'(vga_b.hcount), 0);
    vga_b.en = 1'b1;

    // en=0 across the frame wrap
    tick(159);
    chk("b_pre_h", int'(vga_b.hcount), 15);
    chk("b_pre_v", int'(vga_b.vcount), 9);
    vga_b.en = 1'b0;
    tick(1);
    chk("b_gw1_fs", int'(vga_b.frame_start), 0);
    chk("b_gw1_h", int'(vga_b.hcount), 15);
    tick(1);
    chk("b_gw2_fs", int'(vga_b.frame_start), 0);
    chk("b_gw2_v", int'(vga_b.vcount), 9);
    vga_b.en = 1'b1;
    tick(1);
    chk("b_gw3_fs", int'(vga_b.frame_start), 1);
    chk("b_gw3_h", int'(vga_b.hcount), 0);
    chk("b_gw3_v", int'(vga_b.vcount), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Free-running VGA raster timing generator for 1024x768@60 (65 MHz pixel clock).
- Produces horizontal/vertical pixel counters, sync flags and blanking flags, plus a start-of-frame strobe.
- Every downstream draw stage aligns its pixels to these outputs, e.g. background, rectangle/char renderers, grid lines.
- Sits at the head of the VGA pipeline; its outputs enter the first draw stage registered and mutually aligned.

Parameters:
- H_VISIBLE, 1024 (vga_pkg::VISIBLE_WIDTH), visible pixels per line
- H_FRONT, 24 (vga_pkg::HORIZONTAL_FRONT_PORCH), pixels from end of visible area to hsync start
- H_SYNC, 136 (vga_pkg::HORIZONTAL_SYNC_PULSE), hsync width in pixels
- H_TOTAL, 1344 (vga_pkg::FULL_WIDTH), pixels per line
- V_VISIBLE, 768 (vga_pkg::VISIBLE_HEIGHT), visible lines
- V_FRONT, 3 (vga_pkg::VERTICAL_FRONT_PORCH), lines from end of visible area to vsync start
- V_SYNC, 6 (vga_pkg::VERTICAL_SYNC_PULSE), vsync width in lines
- V_TOTAL, 806 (vga_pkg::FULL_HEIGHT), lines per frame
- CNT_W, 11, counter width; must satisfy 2**CNT_W >= max(H_TOTAL, V_TOTAL)

Ports:
- clk  in  1  pixel clock, 65 MHz
- rst_n  in  1  asynchronous active-low reset
- en  in  1  pixel enable; counters advance only when en=1. Tie to 1 for a native pixel clock.
- hcount  out  CNT_W  current pixel column, 0..H_TOTAL-1
- vcount  out  CNT_W  current line, 0..V_TOTAL-1
- hblnk  out  1  high when hcount >= H_VISIBLE
- vblnk  out  1  high when vcount >= V_VISIBLE
- hsync  out  1  high when H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC
- vsync  out  1  high when V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC
- frame_start  out  1  one-cycle pulse when (hcount,vcount) becomes (0,0) through counting

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n), applied immediately on assertion; release is synchronous to clk.
- Reset values: hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=0, vsync=0, frame_start=0.
- All outputs are flops. Flags are computed combinationally from the next counter values and registered in the same cycle as the counters, so every flag always describes the hcount/vcount it is presented with. Latency between a counter value and its flags is 0.
- Counting (only on cycles with en=1):
  - hcount increments.
  - When hcount == H_TOTAL-1: hcount -> 0 and vcount increments.
  - When additionally vcount == V_TOTAL-1: vcount -> 0.
  - Both wraps happen in the same cycle.
- en=0: all outputs hold their values, and frame_start is driven 0 in that cycle.
- frame_start = 1 for exactly the cycle in which the registered counters first show (0,0) after the (H_TOTAL-1, V_TOTAL-1) position. It is not asserted on reset release; the first pulse comes after one full frame.
- Sync polarity: flags are active-high. Any panel-level inversion belongs in the top level, not in this block.
- Reset asserted mid-frame: all outputs go to reset values at once. Counting restarts from (0,0) on the first en=1 edge after release; no partial pulse is emitted.
- No comparison may overflow. Boundary constants are evaluated at CNT_W width, and the max counter value is H_TOTAL-1 = 1343 < 2048.
- Frame period with en=1 constantly: H_TOTAL*V_TOTAL = 1,083,264 cycles.

Decomposition:
- Timing constants stay in vga_pkg. Add derived localparams there:
  - H_SYNC_START = 1048, H_SYNC_END = 1184
  - V_SYNC_START = 771, V_SYNC_END = 777
  - CNT_W = 11
- Add a typedef to vga_pkg: vga_if_t, a packed struct of {vcount, vsync, vblnk, hcount, hsync, hblnk}, for downstream stage ports.
- One natural sub-module: vga_axis_counter, a generic wrap counter with sync/blank compare, instantiated once per axis. The vertical instance is enabled by the horizontal wrap.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles -> all outputs 0. Release with en=1 -> hcount reads 1,2,3 on successive cycles; vcount=0; no frame_start.
- Horizontal flags: from reset, step to hcount=1023 -> hblnk=0. Next cycle hcount=1024 -> hblnk=1. hsync=1 exactly for hcount 1048..1183 (136 cycles).
- Line wrap: at hcount=1343 -> next cycle hcount=0, vcount+1, hblnk=0.
- Frame wrap: (1343,805) -> next cycle (0,0) with frame_start=1 for one cycle, vblnk=0. vsync=1 exactly for vcount 771..776; vblnk=1 for 768..805. Consecutive frame_start pulses are 1,083,264 cycles apart.
- Enable: toggle en 1,0,0,1 at hcount=500 -> outputs hold at 501 for 2 cycles, then 502. Gate en=0 across the frame wrap -> frame_start is issued only on the enabled cycle.
- Async reset mid-frame: assert rst_n=0 at (700,400) between clock edges -> outputs zero before the next edge. After release, counting resumes from 0.
